// File: rtl/mem_byte_seq_pkg.sv
// Shared definitions for the byte-sequencing memory initiator: size codes,
// state encoding, bus widths and small request-decoding helpers.
package mem_byte_seq_pkg;

  localparam int ByteBus    = 8;
  localparam int MemAddrBus = 32;
  localparam int DataBus    = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    XFER  = 2'b01,
    DRAIN = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Index of the final byte in a request; the reserved code 11 behaves as a word.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SizeByte: return 2'd0;
      SizeHalf: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SizeByte: return False;
      SizeHalf: return addr_lo[0];
      default:  return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq_if.sv
// Request, response and byte-wide memory signals of the sequencer, bundled.
// master is the sequencer's view; slave is the view of its surroundings.
interface mem_byte_seq_if
  import mem_byte_seq_pkg::*;
#(
  parameter int ADDR_W = MemAddrBus
);

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_signed;
  logic [ADDR_W-1:0]  req_addr;
  logic [DataBus-1:0] req_wdata;

  logic               resp_valid;
  logic [DataBus-1:0] resp_rdata;
  logic               resp_err;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_addr;
  logic [ByteBus-1:0] mem_w_data;
  logic [ByteBus-1:0] mem_r_data;
  logic               mem_done;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_r_data, mem_done,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_w_data
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_r_data, mem_done,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_w_data
  );

endinterface

// File: rtl/mem_byte_seq_extend.sv
// Combinational lane select and sign/zero extension of assembled load data
// (byte from lane 0, half from lanes 0-1, word unchanged).
module mem_seq_extend
  import mem_byte_seq_pkg::*;
(
  input  logic [DataBus-1:0] data,
  input  logic [1:0]         size,
  input  logic               signed_ext,
  output logic [DataBus-1:0] result
);

  always_comb begin
    result = data;
    case (size)
      SizeByte: result = {{24{signed_ext & data[7]}}, data[7:0]};
      SizeHalf: result = {{16{signed_ext & data[15]}}, data[15:0]};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/mem_byte_seq.sv
// Splits 1/2/4-byte load/store requests into little-endian byte transfers and
// reassembles loads. Optional MEM_SEQ_ALIGN_CHECK_EN faults misaligned requests.
module mem_byte_seq
  import mem_byte_seq_pkg::*;
#(
  parameter int ADDR_W = MemAddrBus
)(
  input  logic clk_in,
  input  logic rst_in,
  mem_byte_seq_if.master bus
);

  state_e state;
  state_e state_nx;

  logic               we_q;
  logic [1:0]         size_q;
  logic               signed_q;
  logic [ADDR_W-1:0]  base_q;
  logic [DataBus-1:0] wdata_q;
  logic [1:0]         idx_q;
  logic [1:0]         last_q;
  logic [DataBus-1:0] asm_q;
  logic               cap_q;
  logic [1:0]         cap_idx_q;
  logic               err_q;

  logic               take;
  logic               bad;
  logic               beat_done;
  logic [DataBus-1:0] ext_data;

  assign take      = (state == IDLE) && bus.req_valid;
  assign beat_done = (state == XFER) && bus.mem_done;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  assign bad = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign bad = False;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = bad ? RESP : XFER;
      XFER:    if (bus.mem_done && (idx_q == last_q)) state_nx = we_q ? RESP : DRAIN;
      DRAIN:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read data lags its accepted strobe by one cycle, so capture is tracked
  // independently of the current beat's stall status.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_q      <= False;
      size_q    <= SizeByte;
      signed_q  <= False;
      base_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= 2'd0;
      last_q    <= 2'd0;
      asm_q     <= '0;
      cap_q     <= False;
      cap_idx_q <= 2'd0;
      err_q     <= False;
    end else begin
      if (take) begin
        we_q     <= bus.req_we;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        base_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        last_q   <= last_index(bus.req_size);
        idx_q    <= 2'd0;
        err_q    <= bad;
        asm_q    <= '0;
      end else if (beat_done && (idx_q != last_q)) begin
        idx_q <= idx_q + 2'd1;
      end
      cap_q     <= beat_done && !we_q;
      cap_idx_q <= idx_q;
      if (cap_q) asm_q[{cap_idx_q, 3'b000} +: ByteBus] <= bus.mem_r_data;
    end
  end

  always_comb begin
    bus.mem_read   = False;
    bus.mem_write  = False;
    bus.mem_addr   = '0;
    bus.mem_w_data = '0;
    if (state == XFER) begin
      bus.mem_read   = !we_q;
      bus.mem_write  = we_q;
      bus.mem_addr   = base_q + ADDR_W'(idx_q);
      bus.mem_w_data = wdata_q[{idx_q, 3'b000} +: ByteBus];
    end
  end

  mem_seq_extend u_extend (
    .data       (asm_q),
    .size       (size_q),
    .signed_ext (signed_q),
    .result     (ext_data)
  );

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = ((state == RESP) && !we_q && !err_q) ? ext_data : '0;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  assign bus.resp_err = (state == RESP) && err_q;
`else
  assign bus.resp_err = False;
`endif

endmodule

// File: tb/tb_mem_byte_seq.sv
// Scoreboard bench for mem_byte_seq: a RAM responder checks byte traffic and a
// monitor checks responses against a word-level reference model.
module tb_mem_byte_seq;
  import mem_byte_seq_pkg::*;

  localparam int ADDR_W = 32;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  mem_byte_seq_if #(.ADDR_W(ADDR_W)) bus ();

  mem_byte_seq #(.ADDR_W(ADDR_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
  } access_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          c0;
    int          s0;
  } resp_t;

  access_t accQ[$];
  resp_t   respQ[$];
  logic [7:0] ram [logic [31:0]];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int stallTotal = 0;
  int doneProb = 100;
  int stallLeft = 0;
  logic [31:0] stallAddr = '0;

  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: actual=absent/extra required=matching event", name);
  endtask

  function automatic logic [7:0] rdMem(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  // Word-level model: byte list, little-endian value and numeric extension.
  task automatic pushExpected(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata, input int c0);
    int n;
    logic bad;
    longint v;
    longint span;
    access_t a;
    resp_t r;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    bad = 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    bad = ((n == 2) && (addr % 2 != 0)) || ((n == 4) && (addr % 4 != 0));
`endif
    r.err = bad;
    r.rdata = 32'd0;
    r.c0 = c0;
    r.s0 = stallTotal;
    if (bad) begin
      r.lat = 1;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        a.we = we;
        a.addr = addr + 32'(i);
        a.data = wdata[8*i +: 8];
        accQ.push_back(a);
        v = v + longint'(rdMem(addr + 32'(i))) * (longint'(1) << (8 * i));
      end
      r.lat = we ? n + 1 : n + 2;
      if (!we) begin
        span = longint'(1) << (8 * n);
        if (sgn && n < 4 && v >= span / 2) v = v - span;
        r.rdata = 32'(v);
      end
    end
    respQ.push_back(r);
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    @(negedge clk_in);
    while (!bus.req_ready && guard < 200) begin
      @(negedge clk_in);
      guard++;
    end
    if (!bus.req_ready) begin
      failNow("ready_timeout");
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    pushExpected(we, size, sgn, addr, wdata, cycle);
    @(posedge clk_in);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((respQ.size() != 0 || accQ.size() != 0) && guard < 500) begin
      @(negedge clk_in);
      guard++;
    end
    if (respQ.size() != 0 || accQ.size() != 0) begin
      failNow("drain_timeout");
      accQ.delete();
      respQ.delete();
    end
    @(negedge clk_in);
  endtask

  // RAM responder: decides mem_done, checks each accepted byte and holds
  // outputs stable across stalls; read data appears one cycle after accept.
  initial begin
    logic ok;
    logic rdPend;
    logic prevStall;
    logic [31:0] rdAddr;
    logic [31:0] prevAddr;
    logic [31:0] prevCtl;
    access_t a;
    rdPend = 1'b0;
    prevStall = 1'b0;
    rdAddr = '0;
    prevAddr = '0;
    prevCtl = '0;
    bus.mem_done = 1'b0;
    bus.mem_r_data = 8'h00;
    forever begin
      @(negedge clk_in);
      bus.mem_r_data = rdPend ? rdMem(rdAddr) : 8'($urandom);
      rdPend = 1'b0;
      if (prevStall) begin
        checkOutput("stall_addr", bus.mem_addr, prevAddr);
        checkOutput("stall_ctl", {22'd0, bus.mem_read, bus.mem_write, bus.mem_w_data}, prevCtl);
      end
      if (bus.mem_read || bus.mem_write) begin
        if (stallLeft > 0 && bus.mem_addr == stallAddr) begin
          ok = 1'b0;
          stallLeft--;
        end else begin
          ok = ($urandom_range(99) < doneProb);
        end
        bus.mem_done = ok;
        prevStall = !ok;
        prevAddr = bus.mem_addr;
        prevCtl = {22'd0, bus.mem_read, bus.mem_write, bus.mem_w_data};
        if (!ok) begin
          stallTotal++;
        end else begin
          if (accQ.size() == 0) begin
            failNow("unexpected_access");
          end else begin
            a = accQ.pop_front();
            checkOutput("acc_addr", bus.mem_addr, a.addr);
            checkOutput("acc_dir", 32'(bus.mem_write), 32'(a.we));
            if (a.we) checkOutput("acc_wdata", 32'(bus.mem_w_data), 32'(a.data));
          end
          if (bus.mem_write) begin
            ram[bus.mem_addr] = bus.mem_w_data;
          end else begin
            rdPend = 1'b1;
            rdAddr = bus.mem_addr;
          end
        end
      end else begin
        bus.mem_done = 1'b0;
        prevStall = 1'b0;
      end
    end
  end

  initial begin
    resp_t r;
    forever begin
      @(negedge clk_in);
      if (bus.resp_valid) begin
        checkOutput("resp_vs_ready", 32'(bus.req_ready), 32'd0);
        if (respQ.size() == 0) begin
          failNow("unexpected_resp");
        end else begin
          r = respQ.pop_front();
          checkOutput("resp_rdata", bus.resp_rdata, r.rdata);
          checkOutput("resp_err", 32'(bus.resp_err), 32'(r.err));
          checkOutput("resp_latency", 32'(cycle - r.c0), 32'(r.lat + stallTotal - r.s0));
        end
      end
    end
  end

  initial begin
    int c0;
    logic [31:0] addr;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
    checkOutput("rst_rdata", bus.resp_rdata, 32'd0);
    checkOutput("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", 32'(bus.mem_w_data), 32'd0);
    rst_in = 1'b0;

    doneProb = 100;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    waitIdle();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    waitIdle();

    ram[32'h7] = 8'h80;
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    waitIdle();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
    waitIdle();

    ram[32'h20] = 8'h34;
    ram[32'h21] = 8'h92;
    stallAddr = 32'h21;
    stallLeft = 2;
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    waitIdle();
    stallLeft = 0;

    applyStimulus(1'b0, 2'b10, 1'b1, 32'hFFFFFFFE, 32'h0);
    waitIdle();
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h33, 32'h0000A55A);
    waitIdle();

    // Reset two cycles into a word load: nothing may come back.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    checkOutput("midrst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
    rst_in = 1'b0;
    accQ.delete();
    respQ.delete();
    repeat (8) @(negedge clk_in);

    // req_valid held high across two back-to-back byte stores.
    @(negedge clk_in);
    c0 = cycle;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h55;
    bus.req_wdata = 32'h000000C3;
    pushExpected(1'b1, 2'b00, 1'b0, 32'h55, 32'h000000C3, c0);
    pushExpected(1'b1, 2'b00, 1'b0, 32'h55, 32'h000000C3, c0 + 3);
    @(negedge clk_in);
    checkOutput("held_ready_c1", 32'(bus.req_ready), 32'd0);
    @(negedge clk_in);
    checkOutput("held_ready_c2", 32'(bus.req_ready), 32'd0);
    @(negedge clk_in);
    checkOutput("held_ready_c3", 32'(bus.req_ready), 32'd1);
    @(negedge clk_in);
    checkOutput("held_second_write", {30'd0, bus.req_ready, bus.mem_write}, 32'd1);
    bus.req_valid = 1'b0;
    waitIdle();

    doneProb = 70;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(3) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(7));
      else addr = 32'($urandom_range(255));
      applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                    addr, $urandom);
    end
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    failNow("watchdog");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
